// File: rtl/usb_rx_decoder.sv
// USB receive decoder: NRZI decode, SYNC detection, bit unstuffing, byte assembly and EOP/error detection.
// All outputs are registered; pulses appear one cycle after the causing line_valid strobe; no backpressure.
module usb_rx_decoder #(
  parameter bit LOW_SPEED = 1'b0
) (
  input  logic       hi_clock,
  input  logic       reset,
  input  logic       line_valid,
  input  logic       dp,
  input  logic       dm,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_active,
  output logic       rx_err_stuff,
  output logic       rx_err_align
);

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ERR} state_t;
  typedef enum logic [1:0] {LS_SE0, LS_J, LS_K, LS_SE1} line_t;

  state_t     state_q, state_d;
  line_t      line_st;
  logic       prev_k_q, prev_k_d;
  logic [2:0] zcnt_q, zcnt_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [6:0] sr_q, sr_d;
  logic [2:0] jcnt_q, jcnt_d;
  logic       se0_seen_q, se0_seen_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       sop_q, sop_d;
  logic       eop_q, eop_d;
  logic       active_q, active_d;
  logic       err_stuff_q, err_stuff_d;
  logic       err_align_q, err_align_d;
  logic       cur_k, bit_in, go_idle, go_err;

  // Low-speed swaps which differential polarity is J; single-ended states are unaffected.
  always_comb begin
    if (dp == dm) begin
      line_st = dp ? LS_SE1 : LS_SE0;
    end else if (dp ^ LOW_SPEED) begin
      line_st = LS_J;
    end else begin
      line_st = LS_K;
    end
  end

  assign cur_k  = (line_st == LS_K);
  assign bit_in = (cur_k == prev_k_q);

  always_comb begin
    state_d     = state_q;
    prev_k_d    = prev_k_q;
    zcnt_d      = zcnt_q;
    ones_d      = ones_q;
    bcnt_d      = bcnt_q;
    sr_d        = sr_q;
    jcnt_d      = jcnt_q;
    se0_seen_d  = se0_seen_q;
    data_d      = data_q;
    active_d    = active_q;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    err_stuff_d = 1'b0;
    err_align_d = 1'b0;
    go_idle     = 1'b0;
    go_err      = 1'b0;

    if (line_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (line_st == LS_K) begin
            state_d  = ST_SYNC;
            prev_k_d = 1'b1;
            zcnt_d   = 3'd1;
          end
        end
        ST_SYNC: begin
          if (line_st == LS_J || line_st == LS_K) begin
            prev_k_d = cur_k;
            if (!bit_in) begin
              zcnt_d = (zcnt_q == 3'd7) ? 3'd7 : zcnt_q + 3'd1;
            end else if (zcnt_q >= 3'd5) begin
              state_d  = ST_DATA;
              sop_d    = 1'b1;
              active_d = 1'b1;
              ones_d   = 3'd0;
              bcnt_d   = 3'd0;
            end else begin
              go_idle = 1'b1;
            end
          end else if (line_st == LS_SE0) begin
            go_idle = 1'b1;
          end else begin
            go_err = 1'b1;
          end
        end
        ST_DATA: begin
          if (line_st == LS_J || line_st == LS_K) begin
            prev_k_d = cur_k;
            // After six ones the next bit is a stuff bit: a 0 is dropped, a 1 is a violation.
            if (ones_q == 3'd6) begin
              if (bit_in) begin
                err_stuff_d = 1'b1;
                go_err      = 1'b1;
              end else begin
                ones_d = 3'd0;
              end
            end else begin
              ones_d = bit_in ? ones_q + 3'd1 : 3'd0;
              sr_d   = {bit_in, sr_q[6:1]};
              bcnt_d = bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) begin
                data_d  = {bit_in, sr_q};
                valid_d = 1'b1;
              end
            end
          end else if (line_st == LS_SE0) begin
            state_d = ST_EOP;
            ones_d  = 3'd0;
          end else begin
            go_err = 1'b1;
          end
        end
        ST_EOP: begin
          if (line_st == LS_J) begin
            eop_d       = 1'b1;
            err_align_d = (bcnt_q != 3'd0);
            active_d    = 1'b0;
            go_idle     = 1'b1;
          end else if (line_st != LS_SE0) begin
            go_err = 1'b1;
          end
        end
        ST_ERR: begin
          if (line_st == LS_SE0) begin
            se0_seen_d = 1'b1;
            jcnt_d     = 3'd0;
          end else if (line_st == LS_J) begin
            if (se0_seen_q || jcnt_q == 3'd7) begin
              go_idle = 1'b1;
            end else begin
              jcnt_d     = jcnt_q + 3'd1;
              se0_seen_d = 1'b0;
            end
          end else begin
            se0_seen_d = 1'b0;
            jcnt_d     = 3'd0;
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    if (go_idle) begin
      state_d    = ST_IDLE;
      prev_k_d   = 1'b0;
      zcnt_d     = 3'd0;
      ones_d     = 3'd0;
      bcnt_d     = 3'd0;
      jcnt_d     = 3'd0;
      se0_seen_d = 1'b0;
    end
    if (go_err) begin
      state_d    = ST_ERR;
      active_d   = 1'b0;
      jcnt_d     = 3'd0;
      se0_seen_d = 1'b0;
    end
  end

  always_ff @(posedge hi_clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prev_k_q    <= 1'b0;
      zcnt_q      <= 3'd0;
      ones_q      <= 3'd0;
      bcnt_q      <= 3'd0;
      sr_q        <= 7'd0;
      jcnt_q      <= 3'd0;
      se0_seen_q  <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      active_q    <= 1'b0;
      err_stuff_q <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_k_q    <= prev_k_d;
      zcnt_q      <= zcnt_d;
      ones_q      <= ones_d;
      bcnt_q      <= bcnt_d;
      sr_q        <= sr_d;
      jcnt_q      <= jcnt_d;
      se0_seen_q  <= se0_seen_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      active_q    <= active_d;
      err_stuff_q <= err_stuff_d;
      err_align_q <= err_align_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_sop       = sop_q;
  assign rx_eop       = eop_q;
  assign rx_active    = active_q;
  assign rx_err_stuff = err_stuff_q;
  assign rx_err_align = err_align_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: full-speed and low-speed instances fed the same logical line states,
// expected output events queued at stimulus time and checked by per-instance monitors.
module tb_usb_rx_decoder;

  localparam logic [1:0] LJ = 2'd0, LK = 2'd1, LSE0 = 2'd2, LSE1 = 2'd3;

  typedef struct packed {
    logic       sop;
    logic       valid;
    logic       eop;
    logic       es;
    logic       ea;
    logic       active;
    logic [7:0] data;
  } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, line_valid;
  logic fs_dp, fs_dm, ls_dp, ls_dm;

  logic [7:0] fs_data, ls_data;
  logic fs_valid, fs_sop, fs_eop, fs_active, fs_es, fs_ea;
  logic ls_valid, ls_sop, ls_eop, ls_active, ls_es, ls_ea;

  usb_rx_decoder #(.LOW_SPEED(1'b0)) u_fs (
    .hi_clock(clk), .reset(rst), .line_valid(line_valid), .dp(fs_dp), .dm(fs_dm),
    .rx_data(fs_data), .rx_valid(fs_valid), .rx_sop(fs_sop), .rx_eop(fs_eop),
    .rx_active(fs_active), .rx_err_stuff(fs_es), .rx_err_align(fs_ea)
  );

  usb_rx_decoder #(.LOW_SPEED(1'b1)) u_ls (
    .hi_clock(clk), .reset(rst), .line_valid(line_valid), .dp(ls_dp), .dm(ls_dm),
    .rx_data(ls_data), .rx_valid(ls_valid), .rx_sop(ls_sop), .rx_eop(ls_eop),
    .rx_active(ls_active), .rx_err_stuff(ls_es), .rx_err_align(ls_ea)
  );

  evt_t q_fs[$];
  evt_t q_ls[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [7:0] exp_data = 8'h00;
  logic [1:0] cur = LJ;
  int   tb_ones = 0;

  task automatic push_evt(input logic sop, input logic valid, input logic [7:0] d,
                          input logic eop, input logic es, input logic ea, input logic active);
    evt_t e;
    if (valid) exp_data = d;
    e = '{sop: sop, valid: valid, eop: eop, es: es, ea: ea, active: active, data: exp_data};
    q_fs.push_back(e);
    q_ls.push_back(e);
  endtask

  task automatic check_evt(input int inst, input evt_t got);
    evt_t want;
    logic empty;
    n_vec++;
    empty = (inst == 0) ? (q_fs.size() == 0) : (q_ls.size() == 0);
    if (empty) begin
      n_miss++;
      $display("FAIL evt inst%0d unexpected output: got %h, want none", inst, got);
    end else begin
      want = (inst == 0) ? q_fs.pop_front() : q_ls.pop_front();
      if (got !== want) begin
        n_miss++;
        $display("FAIL evt inst%0d sop/valid/eop/es/ea/active/data: got %h, want %h", inst, got, want);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (fs_sop || fs_valid || fs_eop || fs_es || fs_ea))
      check_evt(0, '{sop: fs_sop, valid: fs_valid, eop: fs_eop, es: fs_es, ea: fs_ea,
                     active: fs_active, data: fs_data});
  end

  always @(negedge clk) begin
    if (!rst && (ls_sop || ls_valid || ls_eop || ls_es || ls_ea))
      check_evt(1, '{sop: ls_sop, valid: ls_valid, eop: ls_eop, es: ls_es, ea: ls_ea,
                     active: ls_active, data: ls_data});
  end

  task automatic check_zero(input string name);
    @(negedge clk);
    n_vec++;
    if ({fs_data, fs_valid, fs_sop, fs_eop, fs_active, fs_es, fs_ea} !== 14'd0) begin
      n_miss++;
      $display("FAIL %s fs outputs: got %h, want 0", name,
               {fs_data, fs_valid, fs_sop, fs_eop, fs_active, fs_es, fs_ea});
    end
    n_vec++;
    if ({ls_data, ls_valid, ls_sop, ls_eop, ls_active, ls_es, ls_ea} !== 14'd0) begin
      n_miss++;
      $display("FAIL %s ls outputs: got %h, want 0", name,
               {ls_data, ls_valid, ls_sop, ls_eop, ls_active, ls_es, ls_ea});
    end
  endtask

  task automatic strobe(input logic [1:0] st);
    @(posedge clk); #1;
    line_valid = 1'b1;
    case (st)
      LJ:      begin fs_dp = 1'b1; fs_dm = 1'b0; ls_dp = 1'b0; ls_dm = 1'b1; end
      LK:      begin fs_dp = 1'b0; fs_dm = 1'b1; ls_dp = 1'b1; ls_dm = 1'b0; end
      LSE0:    begin fs_dp = 1'b0; fs_dm = 1'b0; ls_dp = 1'b0; ls_dm = 1'b0; end
      default: begin fs_dp = 1'b1; fs_dm = 1'b1; ls_dp = 1'b1; ls_dm = 1'b1; end
    endcase
    @(posedge clk); #1;
    line_valid = 1'b0;
    // Line levels are junk between strobes and must be ignored.
    {fs_dp, fs_dm, ls_dp, ls_dm} = 4'($urandom);
    repeat (2) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (!b) cur = (cur == LJ) ? LK : LJ;
    strobe(cur);
  endtask

  task automatic send_data_bit(input logic b, input logic stuff_en);
    send_bit(b);
    tb_ones = b ? tb_ones + 1 : 0;
    if (stuff_en && tb_ones == 6) begin
      send_bit(1'b0);
      tb_ones = 0;
    end
  endtask

  task automatic send_sync();
    push_evt(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (7) send_bit(1'b0);
    send_bit(1'b1);
    tb_ones = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    push_evt(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send_data_bit(b[i], 1'b1);
  endtask

  task automatic send_eop(input logic align);
    push_evt(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, align, 1'b0);
    strobe(LSE0);
    strobe(LSE0);
    cur = LJ;
    tb_ones = 0;
    strobe(LJ);
  endtask

  task automatic idle(input int n);
    cur = LJ;
    repeat (n) strobe(LJ);
  endtask

  initial begin
    rst = 1'b1;
    line_valid = 1'b0;
    {fs_dp, fs_dm, ls_dp, ls_dm} = 4'b1001;
    repeat (3) @(posedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    // SE1 in IDLE is ignored.
    idle(2);
    strobe(LSE1);
    strobe(LSE1);
    idle(2);

    // Basic packet.
    send_sync();
    send_byte(8'h69);
    send_byte(8'h00);
    send_byte(8'h10);
    send_eop(1'b0);
    idle(3);

    // All-ones payload with stuff bits inserted.
    send_sync();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_eop(1'b0);
    idle(3);

    // Seven ones without a stuff bit inside the second byte.
    send_sync();
    send_byte(8'h00);
    push_evt(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) send_bit(1'b1);
    strobe(LSE0);
    cur = LJ;
    strobe(LJ);
    idle(3);
    send_sync();
    send_byte(8'h55);
    send_byte(8'hAA);
    send_eop(1'b0);
    idle(3);

    // Twelve data bits then EOP: one byte plus an aligned-error EOP.
    send_sync();
    send_byte(8'hA5);
    send_data_bit(1'b1, 1'b1);
    send_data_bit(1'b0, 1'b1);
    send_data_bit(1'b1, 1'b1);
    send_data_bit(1'b1, 1'b1);
    send_eop(1'b1);
    idle(3);

    // Reset mid-packet after four data bits.
    send_sync();
    send_data_bit(1'b1, 1'b1);
    send_data_bit(1'b0, 1'b1);
    send_data_bit(1'b1, 1'b1);
    send_data_bit(1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    check_zero("mid_packet_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_data = 8'h00;
    cur = LJ;
    tb_ones = 0;
    idle(2);
    send_sync();
    send_byte(8'h3C);
    send_byte(8'hC3);
    send_eop(1'b0);
    idle(2);

    repeat (10) @(posedge clk);
    n_vec++;
    if (q_fs.size() != 0) begin
      n_miss++;
      $display("FAIL fs_pending events: got %0d left, want 0", q_fs.size());
    end
    n_vec++;
    if (q_ls.size() != 0) begin
      n_miss++;
      $display("FAIL ls_pending events: got %0d left, want 0", q_ls.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
